// File: rtl/conv_window_feeder.sv
// conv_window_feeder: streams one KxK window of (weight, pixel) pairs from two
// synchronous-read memories into the MAC chain. It uses a valid/ready handshake
// and a 2-entry head/skid buffer that soaks up the one-cycle read latency.
module conv_window_feeder #(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,      // active-high despite the name
    input  logic              start,
    input  logic [ADDR_W-1:0] win_row,
    input  logic [ADDR_W-1:0] win_col,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] px_addr,
    input  logic [DATA_W-1:0] w_rdata,
    input  logic [DATA_W-1:0] px_rdata,
    output logic [DATA_W-1:0] out_weight,
    output logic [DATA_W-1:0] out_input,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] KM1 = ADDR_W'(K - 1);

    state_t              r_state, w_state_nxt;

    logic [ADDR_W-1:0]   r_row, r_col, r_kr, r_kc;
    logic [ADDR_W-1:0]   r_w_addr, r_px_addr;
    logic                r_pend, r_pend_last;

    logic                r_head_vld, r_head_last;
    logic [DATA_W-1:0]   r_head_w, r_head_px;
    logic                r_skid_vld, r_skid_last;
    logic [DATA_W-1:0]   r_skid_w, r_skid_px;

    logic                w_last_idx, w_pop, w_room, w_rd_en;
    logic                w_drain_done, w_accept;
    logic [1:0]          w_inflight;
    logic [ADDR_W-1:0]   w_kr_nxt, w_kc_nxt;

    // Pixel address of window element (kr,kc); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] f_px(input logic [ADDR_W-1:0] row,
                                               input logic [ADDR_W-1:0] col,
                                               input logic [ADDR_W-1:0] kr,
                                               input logic [ADDR_W-1:0] kc);
        logic [ADDR_W-1:0] v_r;
        v_r = row + kr;
        return (v_r * ADDR_W'(IMG_W)) + col + kc;
    endfunction

    assign w_last_idx   = (r_kr == KM1) && (r_kc == KM1);
    assign w_kc_nxt     = (r_kc == KM1) ? '0 : r_kc + 1'b1;
    assign w_kr_nxt     = (r_kc == KM1) ? r_kr + 1'b1 : r_kr;

    // A read may only be issued if its data will find a free buffer slot.
    assign w_pop        = r_head_vld && out_ready;
    assign w_inflight   = {1'b0, r_head_vld} + {1'b0, r_skid_vld} + {1'b0, r_pend};
    assign w_room       = (w_inflight - {1'b0, w_pop}) < 2'd2;
    assign w_rd_en      = (r_state == S_ISSUE) && w_room;

    assign w_drain_done = (r_state == S_DRAIN) && !r_head_vld && !r_skid_vld && !r_pend;
    assign w_accept     = start && ((r_state == S_IDLE) || w_drain_done);

    assign busy         = (r_state != S_IDLE) && !w_drain_done;
    assign done         = w_drain_done;
    assign mem_rd_en    = w_rd_en;
    assign w_addr       = r_w_addr;
    assign px_addr      = r_px_addr;
    assign out_valid    = r_head_vld;
    assign out_weight   = r_head_w;
    assign out_input    = r_head_px;
    assign out_last     = r_head_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: the done cycle may directly accept a new window.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_rd_en && w_last_idx) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = start ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window origin, raster counters, registered addresses and read-pending tag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_w_addr    <= '0;
            r_px_addr   <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row     <= win_row;
                r_col     <= win_col;
                r_kr      <= '0;
                r_kc      <= '0;
                r_w_addr  <= '0;
                r_px_addr <= f_px(win_row, win_col, '0, '0);
            end else if (w_rd_en && !w_last_idx) begin
                r_kr      <= w_kr_nxt;
                r_kc      <= w_kc_nxt;
                r_w_addr  <= r_w_addr + 1'b1;
                r_px_addr <= f_px(r_row, r_col, w_kr_nxt, w_kc_nxt);
            end
            r_pend      <= w_rd_en;
            r_pend_last <= w_rd_en && w_last_idx;
        end
    end

    // Head/skid FIFO: returning data goes to head when it is free or being freed.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_head_vld  <= 1'b0;
            r_head_last <= 1'b0;
            r_head_w    <= '0;
            r_head_px   <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_w    <= '0;
            r_skid_px   <= '0;
        end else if (r_skid_vld && w_pop) begin
            r_head_vld  <= 1'b1;
            r_head_last <= r_skid_last;
            r_head_w    <= r_skid_w;
            r_head_px   <= r_skid_px;
            r_skid_vld  <= r_pend;
            if (r_pend) begin
                r_skid_last <= r_pend_last;
                r_skid_w    <= w_rdata;
                r_skid_px   <= px_rdata;
            end
        end else if (!r_head_vld || w_pop) begin
            r_head_vld <= r_pend;
            if (r_pend) begin
                r_head_last <= r_pend_last;
                r_head_w    <= w_rdata;
                r_head_px   <= px_rdata;
            end
        end else if (r_pend) begin
            r_skid_vld  <= 1'b1;
            r_skid_last <= r_pend_last;
            r_skid_w    <= w_rdata;
            r_skid_px   <= px_rdata;
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder (K=3, IMG_W=8, ADDR_W=8, DATA_W=16).
// Weight memory returns addr+1, pixel memory returns addr.
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [7:0]  win_row, win_col;
    logic        busy, done, mem_rd_en, out_valid, out_last;
    logic [7:0]  w_addr, px_addr;
    logic [15:0] w_rdata, px_rdata, out_weight, out_input;

    int errors = 0;
    int checks = 0;

    conv_window_feeder #(.DATA_W(16), .K(3), .IMG_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .w_addr(w_addr), .px_addr(px_addr),
        .w_rdata(w_rdata), .px_rdata(px_rdata), .out_weight(out_weight), .out_input(out_input),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory models with one-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            w_rdata  <= {8'd0, w_addr} + 16'd1;
            px_rdata <= {8'd0, px_addr};
        end
    end

    function automatic int exp_px(input int row, input int col, input int idx);
        return ((row + idx / 3) * 8 + col + idx % 3) % 256;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b1; win_row = 8'd0; win_col = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done); end
        checks++; if (mem_rd_en !== 1'b0 || w_addr !== 8'd0 || px_addr !== 8'd0) begin errors++; $display("FAIL reset_mem rd=%b wa=%0d pa=%0d want 0", mem_rd_en, w_addr, px_addr); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_weight !== 16'd0 || out_input !== 16'd0) begin errors++; $display("FAIL reset_out v=%b l=%b w=%0d i=%0d want 0", out_valid, out_last, out_weight, out_input); end
    endtask

    // Full window with out_ready=1; checks every cycle from t+1 to t+13.
    task automatic test_window(input int row, input int col, input string tag);
        logic e_rd, e_v;
        int   idx;
        @(posedge clk); #1 start = 1'b1; win_row = 8'(row); win_col = 8'(col);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            e_rd = (k >= 1 && k <= 9);
            e_v  = (k >= 3 && k <= 11);
            checks++; if (mem_rd_en !== e_rd) begin errors++; $display("FAIL %s_rd k=%0d got %b want %b", tag, k, mem_rd_en, e_rd); end
            if (e_rd) begin
                idx = k - 1;
                checks++; if (w_addr !== 8'(idx) || px_addr !== 8'(exp_px(row, col, idx))) begin errors++; $display("FAIL %s_addr k=%0d got wa=%0d pa=%0d want wa=%0d pa=%0d", tag, k, w_addr, px_addr, idx, exp_px(row, col, idx)); end
            end
            checks++; if (out_valid !== e_v) begin errors++; $display("FAIL %s_valid k=%0d got %b want %b", tag, k, out_valid, e_v); end
            if (e_v) begin
                idx = k - 3;
                checks++; if (out_weight !== 16'(idx + 1) || out_input !== 16'(exp_px(row, col, idx)) || out_last !== (idx == 8)) begin errors++; $display("FAIL %s_pair k=%0d got (%0d,%0d,l=%b) want (%0d,%0d,l=%b)", tag, k, out_weight, out_input, out_last, idx + 1, exp_px(row, col, idx), idx == 8); end
            end
            checks++; if (done !== (k == 12) || busy !== (k <= 11)) begin errors++; $display("FAIL %s_ctl k=%0d got done=%b busy=%b want done=%b busy=%b", tag, k, done, busy, k == 12, k <= 11); end
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int dn = 0;
        @(posedge clk); #1 start = 1'b1; win_row = 8'd0; win_col = 8'd0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1 start = 1'b0; out_ready = !(k >= 6 && k <= 9);
            @(negedge clk);
            if (k >= 6 && k <= 9) begin
                checks++; if (out_valid !== 1'b1 || out_weight !== 16'd4 || out_input !== 16'd8) begin errors++; $display("FAIL bp_hold k=%0d got v=%b (%0d,%0d) want 1 (4,8)", k, out_valid, out_weight, out_input); end
                checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_stall k=%0d rd=%b want 0", k, mem_rd_en); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_weight !== 16'(hs + 1) || out_input !== 16'(exp_px(0, 0, hs)) || out_last !== (hs == 8)) begin errors++; $display("FAIL bp_pair n=%0d got (%0d,%0d,l=%b) want (%0d,%0d,l=%b)", hs, out_weight, out_input, out_last, hs + 1, exp_px(0, 0, hs), hs == 8); end
                hs++;
            end
            if (done) dn++;
        end
        checks++; if (hs !== 9 || dn !== 1) begin errors++; $display("FAIL bp_count got hs=%0d done=%0d want 9 1", hs, dn); end
    endtask

    task automatic test_start_ignored();
        int rd1 = 0;
        int rd2 = 0;
        int dn2 = 0;
        @(posedge clk); #1 start = 1'b1; win_row = 8'd0; win_col = 8'd0;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1
            start = (k == 4 || k == 10 || k == 12);
            win_row = (k == 12) ? 8'd2 : 8'd5;
            win_col = (k == 12) ? 8'd3 : 8'd5;
            @(negedge clk);
            if (k <= 12 && mem_rd_en) rd1++;
            if (k > 12 && mem_rd_en) rd2++;
            if (k == 11) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_drain got busy=%b done=%b want 1 0", busy, done); end
            end
            if (k == 12) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_done got done=%b busy=%b want 1 0", done, busy); end
            end
            if (k == 13) begin
                checks++; if (mem_rd_en !== 1'b1 || w_addr !== 8'd0 || px_addr !== 8'd19) begin errors++; $display("FAIL ign_restart got rd=%b wa=%0d pa=%0d want 1 0 19", mem_rd_en, w_addr, px_addr); end
            end
            if (k > 12 && done) dn2++;
            if (k == 24) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done2 got %b want 1", done); end
            end
        end
        start = 1'b0;
        checks++; if (rd1 !== 9 || rd2 !== 9 || dn2 !== 1) begin errors++; $display("FAIL ign_reads got %0d/%0d done2=%0d want 9/9 1", rd1, rd2, dn2); end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1 start = 1'b1; win_row = 8'd0; win_col = 8'd0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1 start = 1'b0; rst_n = (k == 8);
            @(negedge clk);
            if (k == 7) begin
                checks++; if (out_valid !== 1'b1 || out_weight !== 16'd5 || out_input !== 16'd9) begin errors++; $display("FAIL mrst_pre got v=%b (%0d,%0d) want 1 (5,9)", out_valid, out_weight, out_input); end
            end
            if (k == 9 || k == 10) begin
                checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || w_addr !== 8'd0 || px_addr !== 8'd0) begin errors++; $display("FAIL mrst_ctl k=%0d busy=%b done=%b rd=%b wa=%0d pa=%0d want 0", k, busy, done, mem_rd_en, w_addr, px_addr); end
                checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_weight !== 16'd0 || out_input !== 16'd0) begin errors++; $display("FAIL mrst_out k=%0d v=%b l=%b w=%0d i=%0d want 0", k, out_valid, out_last, out_weight, out_input); end
            end
        end
        test_window(0, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_window(0, 0, "basic");
        test_window(2, 3, "offset");
        test_backpressure();
        test_start_ignored();
        test_reset_midstream();
        test_window(31, 6, "wrap");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Source end of the weight/input pipeline that feeds the MAC chain.
- For one KxK convolution window, reads kernel weights and image pixels from two synchronous-read memories (1-cycle read latency).
- Emits one (weight, input) pair per cycle with a valid/ready handshake. out_valid drives the downstream pipeline-stage enable.
- A 2-entry output buffer absorbs memory latency under backpressure without losing or duplicating pairs.

Parameters:
DATA_W, 16, width of weight and pixel words
K, 3, kernel size; K*K pairs per window (K >= 1)
IMG_W, 8, image row width in pixels
ADDR_W, 8, memory address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset (asserted = 1), sampled on rising edge of clk
start  in  1  one-cycle request to stream a window; ignored while busy
win_row  in  ADDR_W  window top-left row, sampled when start accepted
win_col  in  ADDR_W  window top-left column, sampled when start accepted
busy  out  1  window in progress
done  out  1  one-cycle pulse after last pair accepted
mem_rd_en  out  1  read strobe to both memories
w_addr  out  ADDR_W  weight memory address
px_addr  out  ADDR_W  pixel memory address
w_rdata  in  DATA_W  weight data, valid cycle after mem_rd_en
px_rdata  in  DATA_W  pixel data, valid cycle after mem_rd_en
out_weight  out  DATA_W  weight of current pair
out_input  out  DATA_W  pixel of current pair
out_valid  out  1  pair valid (downstream enable)
out_ready  in  1  downstream accepts pair
out_last  out  1  current pair is index K*K-1

Behaviour:
- Reset (rst_n=1 at edge): FSM=IDLE, counters=0, buffer empty, read-pending flag cleared. All outputs 0 next cycle. In-flight read data discarded. Reset wins over start.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 latches win_row/win_col, clears kr/kc, goes to ISSUE, busy=1 from next cycle.
  - ISSUE: issues reads until K*K issued, then DRAIN.
  - DRAIN: waits until buffer empty and no read pending after the out_last handshake, then pulses done for 1 cycle and returns to IDLE. busy=0 in the done cycle.
- Read order: raster; kr outer, kc inner; pair index i = kr*K+kc.
- Addresses (registered, valid when mem_rd_en=1):
  - w_addr = kr*K + kc
  - px_addr = (win_row+kr)*IMG_W + (win_col+kc)
  - Both computed modulo 2^ADDR_W.
  - No bounds clipping; keeping the window inside the image is the caller's responsibility.
- Read issue rule: mem_rd_en=1 only in ISSUE and only when (occupied entries + pending read − entry leaving this cycle) < 2. Leaving this cycle means out_valid && out_ready.
- Returned data is written to the head register if it is free or being freed this cycle; otherwise to the skid register.
- Buffer order is FIFO; out_* always reflect the head entry. The head entry is stable while out_valid=1 and out_ready=0.
- out_last travels with pair index K*K-1.
- Latency with out_ready=1 (start sampled at edge ending cycle t):
  - mem_rd_en=1 cycles t+1 .. t+K*K
  - out_valid=1 cycles t+3 .. t+K*K+2, one pair per cycle
  - done=1 at cycle t+K*K+3
- Throughput: 1 pair/cycle with no backpressure.
- out_ready may be high while out_valid=0; this has no effect.
- start is ignored while busy=1, including during the DRAIN state.
- start in the same cycle as done (busy=0) is accepted.
- When out_valid=0, out_weight, out_input and out_last hold their last value.

Test Plan:
- K=3, IMG_W=8, win=(0,0), weight mem[i]=i+1, pixel mem[a]=a, out_ready=1 -> pairs (1,0),(2,1),(3,2),(4,8),(5,9),(6,10),(7,16),(8,17),(9,18) on consecutive cycles t+3..t+11; out_last only on (9,18); done at t+12.
- win=(2,3), same memories -> px_addr sequence 19,20,21,27,28,29,35,36,37; w_addr 0..8.
- out_ready=0 for 4 cycles while pair 4 (4,8) is valid -> (4,8) held stable; mem_rd_en=0 once buffer plus pending reach 2; after release the remaining pairs follow in order with no loss or duplication; total exactly 9 handshakes.
- start pulsed during streaming and during DRAIN -> ignored, no extra reads; start in the done cycle -> new window begins, mem_rd_en next cycle.
- rst_n=1 asserted after pair 5 while a read is pending -> next cycle all outputs 0 and busy=0; stale rdata never appears on out_*; a fresh start then produces the full correct 9-pair sequence.
- ADDR_W=8, IMG_W=8, win=(31,6) -> px_addr wraps modulo 256 (first address 254, then 255, 0).
